// File: rtl/gshare_pkg.sv
// Shared types for the gshare predictor.
//   pht_state_t     : 2-bit saturating counter state (SNT/WNT/WT/ST)
//   PHT_RESET_STATE : value every PHT entry takes on reset (weakly not-taken)
package gshare_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } pht_state_t;

   localparam pht_state_t PHT_RESET_STATE = WNT;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for one 2-bit saturating branch counter.
// Ports:
//   en    in   1  update enable; when low nxt = cur
//   taken in   1  resolved outcome
//   cur   in   2  current counter state
//   nxt   out  2  next counter state (saturates at SNT and ST)
module sat_counter2
   import gshare_pkg::*;
(
   input  logic       en,
   input  logic       taken,
   input  pht_state_t cur,
   output pht_state_t nxt
);

   always_comb begin
      nxt = cur;
      if (en) begin
         case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = cur;
         endcase
      end
   end

endmodule

// File: rtl/gshare_pht.sv
// Gshare predictor storage: global history register plus a table of 2-bit
// counters indexed by PC ^ GHR. Lookup is combinational; updates from EX are
// applied on the rising edge and become visible the following cycle.
// Optional feature: define GSHARE_STATS_EN to build saturating resolved-branch
// and mispredict counters; otherwise both count ports are tied to zero.
// Ports:
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_f_valid, i_f_pc     fetch lookup request
//   o_f_taken, o_f_idx    prediction and the PHT index it used
//   i_u_valid, i_u_idx    resolved branch update and its carried index
//   i_u_taken             actual outcome
//   i_u_mispred           mispredict flag (statistics only)
//   o_ghr                 current global history (debug)
//   o_br_cnt              resolved-branch count
//   o_mispred_cnt         mispredict count
module gshare_pht
   import gshare_pkg::*;
#(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned IDX_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_f_valid,
   input  logic [PC_W-1:0]  i_f_pc,
   output logic             o_f_taken,
   output logic [IDX_W-1:0] o_f_idx,
   input  logic             i_u_valid,
   input  logic [IDX_W-1:0] i_u_idx,
   input  logic             i_u_taken,
   input  logic             i_u_mispred,
   output logic [IDX_W-1:0] o_ghr,
   output logic [31:0]      o_br_cnt,
   output logic [31:0]      o_mispred_cnt
);

   localparam int unsigned DEPTH = 2 ** IDX_W;

   // Flop array rather than RAM: every entry must clear on async reset.
   pht_state_t       pht [DEPTH];
   logic [IDX_W-1:0] ghr;
   pht_state_t       upd_next;

   // PC bits outside the index window do not participate in the hash.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_f_pc[PC_W-1:IDX_W+2], i_f_pc[1:0]};

   assign o_f_idx   = i_f_pc[IDX_W+1:2] ^ ghr;
   // Reads the registered entry, so a same-cycle update to this index is not bypassed.
   assign o_f_taken = i_f_valid & pht[o_f_idx][1];
   assign o_ghr     = ghr;

   sat_counter2 u_sat_counter2 (
      .en    (i_u_valid),
      .taken (i_u_taken),
      .cur   (pht[i_u_idx]),
      .nxt   (upd_next)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pht[i] <= PHT_RESET_STATE;
         end
         ghr <= '0;
      end else if (i_u_valid) begin
         pht[i_u_idx] <= upd_next;
         ghr          <= {ghr[IDX_W-2:0], i_u_taken};
      end
   end

`ifdef GSHARE_STATS_EN
   logic [31:0] br_cnt;
   logic [31:0] mispred_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         br_cnt      <= '0;
         mispred_cnt <= '0;
      end else if (i_u_valid) begin
         if (br_cnt != '1) begin
            br_cnt <= br_cnt + 32'd1;
         end
         if (i_u_mispred && (mispred_cnt != '1)) begin
            mispred_cnt <= mispred_cnt + 32'd1;
         end
      end
   end

   assign o_br_cnt      = br_cnt;
   assign o_mispred_cnt = mispred_cnt;
`else
   logic unused_mispred;
   assign unused_mispred = i_u_mispred;
   assign o_br_cnt       = '0;
   assign o_mispred_cnt  = '0;
`endif

endmodule
